// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline.
// Drives PC/IF-ID/ID-EX/EX-MEM/MEM-WB write enables and bubble controls.
//
// Parameters:
//   REG_AW  register-address width
//   CNT_W   performance counter width
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   id_rs, id_rt           source registers of the ID instruction
//   id_uses_rs/rt          ID instruction reads the matching source
//   id_halt                ID instruction is HALT
//   ex_mem_read            EX instruction is a load
//   ex_reg_write, ex_rd    EX instruction destination write
//   ex_branch_taken        EX resolved a taken branch/jump
//   mem_busy               data memory not ready this cycle
//   pc_we, *_we            PC and pipeline-register write enables
//   ifid_flush, idex_flush load a NOP bubble into the register
//   halted                 pipeline fully drained after HALT
//   stall_cycles           saturating count of load-use and busy cycles
//   flush_count            saturating count of taken-branch flushes
module pipeline_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_halt,
    input  logic              ex_mem_read,
    input  logic              ex_reg_write,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_branch_taken,
    input  logic              mem_busy,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              idex_we,
    output logic              exmem_we,
    output logic              memwb_we,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       cnt;
    logic [1:0]       cnt_nxt;
    logic             stall_inc;
    logic             flush_inc;
    logic             load_use;
    logic             rs_hit;
    logic             rt_hit;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    // A load into r0 never produces a value, so it can't create a hazard.
    assign rs_hit   = id_uses_rs && (id_rs == ex_rd);
    assign rt_hit   = id_uses_rt && (id_rt == ex_rd);
    assign load_use = ex_mem_read && ex_reg_write
                   && (ex_rd != '0) && (rs_hit || rt_hit);

    always_comb begin
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        idex_we    = 1'b0;
        exmem_we   = 1'b0;
        memwb_we   = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        state_nxt  = state;
        cnt_nxt    = cnt;

        if (reset) begin
            // Clock bubbles into every stage while PC holds.
            ifid_we    = 1'b1;
            idex_we    = 1'b1;
            exmem_we   = 1'b1;
            memwb_we   = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_nxt  = ST_RUN;
            cnt_nxt    = 2'd0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (mem_busy) begin
                        stall_inc = 1'b1;
                    end else if (ex_branch_taken) begin
                        // ID instruction is squashed, so its hazards
                        // and HALT do not matter.
                        pc_we      = 1'b1;
                        ifid_we    = 1'b1;
                        idex_we    = 1'b1;
                        exmem_we   = 1'b1;
                        memwb_we   = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        flush_inc  = 1'b1;
                    end else if (load_use) begin
                        idex_we    = 1'b1;
                        idex_flush = 1'b1;
                        exmem_we   = 1'b1;
                        memwb_we   = 1'b1;
                        stall_inc  = 1'b1;
                    end else if (id_halt) begin
                        // HALT moves on into EX; fetch stops.
                        idex_we   = 1'b1;
                        exmem_we  = 1'b1;
                        memwb_we  = 1'b1;
                        state_nxt = ST_DRAIN;
                        cnt_nxt   = 2'd2;
                    end else begin
                        pc_we    = 1'b1;
                        ifid_we  = 1'b1;
                        idex_we  = 1'b1;
                        exmem_we = 1'b1;
                        memwb_we = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (mem_busy) begin
                        stall_inc = 1'b1;
                    end else begin
                        idex_we    = 1'b1;
                        idex_flush = 1'b1;
                        exmem_we   = 1'b1;
                        memwb_we   = 1'b1;
                        if (cnt != 2'd0) begin
                            cnt_nxt = cnt - 2'd1;
                        end else begin
                            state_nxt = ST_HALTED;
                        end
                    end
                end
                ST_HALTED: begin
                    state_nxt = ST_HALTED;
                end
                default: begin
                    state_nxt = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_RUN;
            cnt     <= 2'd0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            // Counters stick at all-ones instead of wrapping.
            if (stall_inc && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
            if (flush_inc && (flush_q != '1)) begin
                flush_q <= flush_q + 1'b1;
            end
        end
    end

    assign halted       = (state == ST_HALTED);
    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl.
// Directed scenarios followed by randomized traffic against a reference model.
module tb_pipeline_hazard_ctrl;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 16;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic              id_halt;
    logic              ex_mem_read;
    logic              ex_reg_write;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_branch_taken;
    logic              mem_busy;
    logic              pc_we;
    logic              ifid_we;
    logic              idex_we;
    logic              exmem_we;
    logic              memwb_we;
    logic              ifid_flush;
    logic              idex_flush;
    logic              halted;
    logic [CNT_W-1:0]  stall_cycles;
    logic [CNT_W-1:0]  flush_count;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: mode 0=running, 1=draining, 2=halted.
    int m_mode = 0;
    int m_drain_left = 0;
    int m_stall = 0;
    int m_flush = 0;

    pipeline_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .reset(reset),
        .id_rs(id_rs),
        .id_rt(id_rt),
        .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt),
        .id_halt(id_halt),
        .ex_mem_read(ex_mem_read),
        .ex_reg_write(ex_reg_write),
        .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken),
        .mem_busy(mem_busy),
        .pc_we(pc_we),
        .ifid_we(ifid_we),
        .idex_we(idex_we),
        .exmem_we(exmem_we),
        .memwb_we(memwb_we),
        .ifid_flush(ifid_flush),
        .idex_flush(idex_flush),
        .halted(halted),
        .stall_cycles(stall_cycles),
        .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare combinational outputs and
    // counters against the model, then advance the model over the edge.
    task automatic cyc(input logic rst, input logic busy, input logic br,
                       input logic halt, input logic mr, input logic rw,
                       input int rd, input int rs, input int rt,
                       input logic urs, input logic urt);
        logic [6:0] exp;
        logic [6:0] obs;
        bit lu;
        @(negedge clk);
        reset = rst;
        mem_busy = busy;
        ex_branch_taken = br;
        id_halt = halt;
        ex_mem_read = mr;
        ex_reg_write = rw;
        ex_rd = REG_AW'(rd);
        id_rs = REG_AW'(rs);
        id_rt = REG_AW'(rt);
        id_uses_rs = urs;
        id_uses_rt = urt;
        #1;
        lu = mr && rw && rd != 0 && ((urs && rs == rd) || (urt && rt == rd));
        // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
        exp = 7'b0000000;
        if (rst) begin
            exp = 7'b0111111;
        end else if (m_mode == 0) begin
            if (busy) exp = 7'b0000000;
            else if (br) exp = 7'b1111111;
            else if (lu) exp = 7'b0011101;
            else if (halt) exp = 7'b0011100;
            else exp = 7'b1111100;
        end else if (m_mode == 1) begin
            exp = busy ? 7'b0000000 : 7'b0011101;
        end
        obs = {pc_we, ifid_we, idex_we, exmem_we, memwb_we,
               ifid_flush, idex_flush};
        check("controls", 32'(obs), 32'(exp));
        if (!rst) begin
            check("halted", 32'(halted), 32'(m_mode == 2));
            check("stall_cycles", 32'(stall_cycles), 32'(m_stall));
            check("flush_count", 32'(flush_count), 32'(m_flush));
        end
        if (rst) begin
            m_mode = 0;
            m_drain_left = 0;
            m_stall = 0;
            m_flush = 0;
        end else if (m_mode == 0) begin
            if (busy || (!br && lu)) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
            else if (br) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
            else if (halt) begin
                m_mode = 1;
                m_drain_left = 3;
            end
        end else if (m_mode == 1) begin
            if (busy) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
            else begin
                m_drain_left--;
                if (m_drain_left == 0) m_mode = 2;
            end
        end
    endtask

    task automatic idle(input logic busy);
        cyc(1'b0, busy, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        do_reset();
        do_reset();
        idle(1'b0);

        // Load-use on rs, then the same with ex_rd=0.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5, 5, 0, 1'b1, 1'b0);
        idle(1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7, 1, 7, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7, 7, 7, 1'b0, 1'b0);
        idle(1'b0);

        // Branch wins over a simultaneous load-use and halt.
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5, 5, 0, 1'b1, 1'b0);
        idle(1'b0);

        // Three busy cycles with a branch pending, then the flush.
        repeat (3) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);

        // Halt drain without busy, halted holds even with branch/busy.
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3, 3, 3, 1'b1, 1'b1);
        repeat (2) idle(1'b0);
        repeat (2) idle(1'b0);
        idle(1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);

        // Halt drain with one busy cycle at t+2.
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);
        repeat (4) idle(1'b0);

        // Reset in the middle of a drain.
        do_reset();
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        idle(1'b1);
        do_reset();
        repeat (3) idle(1'b0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 63) == 0,
                $urandom_range(0, 4) == 0,
                $urandom_range(0, 5) == 0,
                $urandom_range(0, 15) == 0,
                1'($urandom), 1'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom));
        end

        // Saturation of the stall counter.
        do_reset();
        repeat (65536) idle(1'b1);
        repeat (3) idle(1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2, 2, 0, 1'b1, 1'b0);
        idle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
